alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 107 ++++++++++
 tb/tb_alu_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issues requests to a fixed 2-cycle-latency ALU and returns results in issue order
// through a credit-protected result FIFO that can never overflow.
module alu_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [3:0]       in_opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [63:0]      alu_z,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_z,
  output logic             out_carry,
  output logic             out_overflow,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 64 + 2 + TAG_W;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  logic             r_s0Valid;
  logic             r_s1Valid;
  logic [TAG_W-1:0] r_s0Tag;
  logic [TAG_W-1:0] r_s1Tag;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [EW-1:0]    r_mem [DEPTH];

  logic [CW:0]      w_credit;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_outValid;
  logic [EW-1:0]    w_head;

  // Every issued op owns a slot from issue onward, so a completing result always fits.
  assign w_credit   = {1'b0, r_count} + (CW + 1)'(r_s0Valid) + (CW + 1)'(r_s1Valid);
  assign in_ready   = rst | (w_credit < LIMIT);
  assign w_issue    = in_valid & in_ready & ~rst;
  assign w_push     = r_s1Valid;
  assign w_outValid = (r_count != '0) & ~rst;
  assign w_pop      = w_outValid & out_ready;

  assign alu_a      = w_issue ? in_a      : '0;
  assign alu_b      = w_issue ? in_b      : '0;
  assign alu_opcode = w_issue ? in_opcode : '0;

  // Head fields come straight from storage but read as zero whenever nothing is presented.
  assign w_head       = r_mem[r_rdPtr];
  assign out_valid    = w_outValid;
  assign out_z        = w_outValid ? w_head[EW-1 -: 64]  : '0;
  assign out_carry    = w_outValid ? w_head[TAG_W + 1]   : 1'b0;
  assign out_overflow = w_outValid ? w_head[TAG_W]       : 1'b0;
  assign out_tag      = w_outValid ? w_head[TAG_W-1:0]   : '0;
  assign busy         = (r_s0Valid | r_s1Valid | (r_count != '0)) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0Valid <= 1'b0;
      r_s1Valid <= 1'b0;
      r_s0Tag   <= '0;
      r_s1Tag   <= '0;
      r_count   <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
    end else begin
      r_s0Valid <= w_issue;
      r_s0Tag   <= in_tag;
      r_s1Valid <= r_s0Valid;
      r_s1Tag   <= r_s0Tag;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever presented.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {alu_z, alu_carry, alu_overflow, r_s1Tag};
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 2-cycle adder ALU attached;
// expected values are hand-computed per step.
module tb_alu_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_a;
  logic [63:0]      in_b;
  logic [3:0]       in_opcode;
  logic [TAG_W-1:0] in_tag;
  logic [63:0]      alu_a;
  logic [63:0]      alu_b;
  logic [3:0]       alu_opcode;
  logic [63:0]      alu_z;
  logic             alu_carry;
  logic             alu_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_z;
  logic             out_carry;
  logic             out_overflow;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checkCount = 0;
  int passCount  = 0;
  int accepted   = 0;

  alu_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_carry(out_carry), .out_overflow(out_overflow), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream ALU: opcode 1000 adds with carry/signed-overflow flags, anything else yields zero.
  logic [64:0] aluSum;
  logic [63:0] aluStageZ;
  logic        aluStageC;
  logic        aluStageV;

  always_comb begin
    aluSum = {1'b0, alu_a} + {1'b0, alu_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aluStageZ    <= '0;
      aluStageC    <= 1'b0;
      aluStageV    <= 1'b0;
      alu_z        <= '0;
      alu_carry    <= 1'b0;
      alu_overflow <= 1'b0;
    end else begin
      if (alu_opcode == 4'b1000) begin
        aluStageZ <= aluSum[63:0];
        aluStageC <= aluSum[64];
        aluStageV <= (alu_a[63] == alu_b[63]) && (aluSum[63] != alu_a[63]);
      end else begin
        aluStageZ <= '0;
        aluStageC <= 1'b0;
        aluStageV <= 1'b0;
      end
      alu_z        <= aluStageZ;
      alu_carry    <= aluStageC;
      alu_overflow <= aluStageV;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] op, input logic [TAG_W-1:0] tag, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    in_tag    = tag;
    out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
  endtask

  initial begin
    // Reset with a request held valid: it must be ignored and all outputs idle.
    rst = 1'b1;
    applyStimulus(1'b1, 64'd9, 64'd9, 4'b1000, 4'd7, 1'b1);
    tick();
    tick();
    checkOutput("rst_in_ready",  64'(in_ready),   64'd1);
    checkOutput("rst_out_valid", 64'(out_valid),  64'd0);
    checkOutput("rst_busy",      64'(busy),       64'd0);
    checkOutput("rst_alu_a",     alu_a,           64'd0);
    checkOutput("rst_alu_op",    64'(alu_opcode), 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b1);
    tick();
    checkOutput("post_rst_busy",  64'(busy),      64'd0);
    checkOutput("post_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("post_rst_z",     out_z,          64'd0);
    checkOutput("post_rst_tag",   64'(out_tag),   64'd0);

    $display("[TB] single op");
    applyStimulus(1'b1, 64'd5, 64'd3, 4'b1000, 4'd2, 1'b1);
    checkOutput("single_alu_a",  alu_a,           64'd5);
    checkOutput("single_alu_b",  alu_b,           64'd3);
    checkOutput("single_alu_op", 64'(alu_opcode), 64'd8);
    checkOutput("single_ready",  64'(in_ready),   64'd1);
    tick();
    applyStimulus(1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b1);
    checkOutput("single_c1_op",    64'(alu_opcode), 64'd0);
    checkOutput("single_c1_busy",  64'(busy),       64'd1);
    checkOutput("single_c1_valid", 64'(out_valid),  64'd0);
    tick();
    checkOutput("single_c2_op",    64'(alu_opcode), 64'd0);
    checkOutput("single_c2_valid", 64'(out_valid),  64'd0);
    tick();
    checkOutput("single_c3_valid", 64'(out_valid),    64'd1);
    checkOutput("single_c3_z",     out_z,             64'd8);
    checkOutput("single_c3_carry", 64'(out_carry),    64'd0);
    checkOutput("single_c3_ovf",   64'(out_overflow), 64'd0);
    checkOutput("single_c3_tag",   64'(out_tag),      64'd2);
    checkOutput("single_c3_op",    64'(alu_opcode),   64'd0);
    tick();
    checkOutput("single_c4_valid", 64'(out_valid), 64'd0);
    checkOutput("single_c4_busy",  64'(busy),      64'd0);

    $display("[TB] flag pass-through");
    applyStimulus(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b1000, 4'd5, 1'b1);
    tick();
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1000, 4'd6, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b1);
    tick();
    checkOutput("ovf_z",     out_z,             64'h8000_0000_0000_0000);
    checkOutput("ovf_ovf",   64'(out_overflow), 64'd1);
    checkOutput("ovf_carry", 64'(out_carry),    64'd0);
    checkOutput("ovf_tag",   64'(out_tag),      64'd5);
    tick();
    checkOutput("carry_z",     out_z,             64'd0);
    checkOutput("carry_carry", 64'(out_carry),    64'd1);
    checkOutput("carry_ovf",   64'(out_overflow), 64'd0);
    checkOutput("carry_tag",   64'(out_tag),      64'd6);
    tick();
    checkOutput("flags_drained", 64'(out_valid), 64'd0);

    $display("[TB] streaming");
    for (int c = 0; c < 12; c++) begin
      if (c < 8) applyStimulus(1'b1, 64'(c * 16), 64'd1, 4'b1000, 4'(c), 1'b1);
      else       applyStimulus(1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b1);
      if (c < 8) checkOutput("stream_ready", 64'(in_ready), 64'd1);
      if (c >= 3 && c <= 10) begin
        checkOutput("stream_valid", 64'(out_valid), 64'd1);
        checkOutput("stream_tag",   64'(out_tag),   64'(c - 3));
        checkOutput("stream_z",     out_z,          64'((c - 3) * 16 + 1));
      end
      if (c == 11) checkOutput("stream_drained", 64'(out_valid), 64'd0);
      tick();
    end

    $display("[TB] backpressure");
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 64'(109 + accepted), 64'd0, 4'b1000, 4'(9 + accepted), 1'b0);
      checkOutput("bp_ready", 64'(in_ready), (c < 4) ? 64'd1 : 64'd0);
      if (c == 5) checkOutput("bp_alu_a_blocked", alu_a, 64'd0);
      if (in_ready) accepted++;
      tick();
    end
    checkOutput("bp_accepted", 64'(accepted), 64'd4);
    checkOutput("bp_busy",     64'(busy),     64'd1);
    for (int d = 0; d < 5; d++) begin
      applyStimulus(1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b1);
      if (d < 4) begin
        checkOutput("drain_valid", 64'(out_valid), 64'd1);
        checkOutput("drain_tag",   64'(out_tag),   64'(9 + d));
        checkOutput("drain_z",     out_z,          64'(109 + d));
        checkOutput("drain_ready", 64'(in_ready),  (d == 0) ? 64'd0 : 64'd1);
      end else begin
        checkOutput("drain_empty", 64'(out_valid), 64'd0);
        checkOutput("drain_ready", 64'(in_ready),  64'd1);
      end
      tick();
    end

    $display("[TB] push and pop at count 2");
    applyStimulus(1'b1, 64'd1, 64'd0, 4'b1000, 4'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 64'd2, 64'd0, 4'b1000, 4'd2, 1'b0);
    tick();
    applyStimulus(1'b1, 64'd3, 64'd0, 4'b1000, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b0);
    checkOutput("pp_c3_tag", 64'(out_tag), 64'd1);
    tick();
    applyStimulus(1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b1);
    checkOutput("pp_c4_tag", 64'(out_tag), 64'd1);
    tick();
    checkOutput("pp_c5_valid", 64'(out_valid), 64'd1);
    checkOutput("pp_c5_tag",   64'(out_tag),   64'd2);
    tick();
    checkOutput("pp_c6_valid", 64'(out_valid), 64'd1);
    checkOutput("pp_c6_tag",   64'(out_tag),   64'd3);
    checkOutput("pp_c6_z",     out_z,          64'd3);
    tick();
    checkOutput("pp_c7_empty", 64'(out_valid), 64'd0);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 64'd1, 64'd1, 4'b1000, 4'd4, 1'b1);
    tick();
    applyStimulus(1'b1, 64'd1, 64'd1, 4'b1000, 4'd5, 1'b1);
    tick();
    applyStimulus(1'b1, 64'd1, 64'd1, 4'b1000, 4'd6, 1'b1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b1);
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_busy",  64'(busy),      64'd0);
    checkOutput("mid_rst_ready", 64'(in_ready),  64'd1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 1'b1);
    checkOutput("after_rst_ready", 64'(in_ready), 64'd1);
    checkOutput("after_rst_busy",  64'(busy),     64'd0);
    for (int c = 0; c < 4; c++) begin
      checkOutput("after_rst_no_valid", 64'(out_valid), 64'd0);
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
